regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WE3/A3/WD3) among NUM_SRC writeback requesters, e.g. ALU, load unit and multiply/divide unit.
- Uses round-robin arbitration, one grant per cycle, and a registered write stage.
- Keeps a 32-entry pending-write scoreboard: the issue stage marks a destination busy at launch, and the bit clears when that write reaches the register file.
- Drives the HAZARD stall for two read addresses.
- Sits between the execute/writeback units and the register file.

Parameters:
- NUM_SRC, 3, number of writeback requesters (2..4).
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  NUM_SRC  per-source write request valid.
- REQ_ADDR  in  NUM_SRC*AW  per-source destination register; source i in bits [i*AW +: AW].
- REQ_DATA  in  NUM_SRC*XLEN  per-source write data; source i in bits [i*XLEN +: XLEN].
- REQ_READY  out  NUM_SRC  one-hot grant; a transfer occurs when VALID&READY.
- WE3  out  1  register-file write enable (registered).
- A3  out  AW  register-file write address (registered).
- WD3  out  XLEN  register-file write data (registered).
- ISSUE_EN  in  1  issue stage launches an op that will write ISSUE_RD.
- ISSUE_RD  in  AW  destination of the launched op.
- CHK_A1  in  AW  read address 1 to check.
- CHK_A2  in  AW  read address 2 to check.
- HAZARD  out  1  combinational: CHK_A1 or CHK_A2 is nonzero and busy.
- SB_BUSY  out  32  scoreboard bits, for debug; bit 0 is always 0.

Behaviour:
- Reset (RST_N low, async): WE3=0, A3=0, WD3=0, round-robin pointer=0, all SB_BUSY=0. REQ_READY=0 while reset is asserted.
- Reset mid-operation discards any in-flight write and all scoreboard state. Requesters must re-present after reset.
- Arbitration (combinational):
  - Search REQ_VALID starting at index ptr, ascending with wrap-around.
  - The first valid source gets REQ_READY=1; all others get 0.
  - No valid source gives REQ_READY=0.
  - The register file never back-pressures, so a grant is always given when any VALID is high.
- Pointer update: on a grant to source g, ptr <= (g+1) mod NUM_SRC. With no grant, ptr holds.
- Write stage (one-cycle latency): a grant in cycle t drives WE3/A3/WD3 during cycle t+1, and the register file commits at the end of t+1.
  - WE3 <= grant & (granted addr != 0).
  - A3/WD3 load the granted addr/data on a grant and hold otherwise.
  - A granted write to x0 is accepted (READY=1) but produces no WE3 pulse.
- Back-to-back grants produce WE3 high on consecutive cycles, for full throughput of one write per cycle.
- Scoreboard, evaluated per register r (r != 0) at each edge:
  - set = ISSUE_EN & ISSUE_RD==r.
  - clr = WE3 & A3==r.
  - Next value: set ? 1 : (clr ? 0 : busy).
  - When set and clr hit the same register in the same cycle, set wins, because the new producer supersedes the old one.
  - Bit 0 is never set.
- Busy covers the commit cycle: during the cycle WE3 is high for r, busy[r]=1 still. The register file read that cycle returns stale data, so HAZARD must be asserted then.
- HAZARD = (CHK_A1!=0 & busy[CHK_A1]) | (CHK_A2!=0 & busy[CHK_A2]). Pure combinational from the registered busy bits; ISSUE_EN in the same cycle has no effect on it.
- Writes need not have been issued through ISSUE_EN (single-cycle ALU ops may write directly). In that case clr on a non-busy bit is a no-op.
- Multiple outstanding writes to the same rd are allowed. The first commit clears busy, and the issue stage is responsible for WAW ordering.

Decomposition:
- Shared package holds AW, XLEN, NUM_SRC defaults and the constant REG_ZERO=5'd0.
- One sub-module is natural: rr_arbiter (NUM_SRC-wide round-robin, REQ -> one-hot GNT plus pointer register).
- The scoreboard and the write stage stay in the top module.

Test Plan:
1. Reset released, no requests -> WE3=0, REQ_READY=0, SB_BUSY=0, HAZARD=0 with CHK_A1=5, CHK_A2=6.
2. Src0 only, addr=5, data=0xDEADBEEF for one cycle -> READY[0]=1 that cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF; following cycle WE3=0.
3. All 3 sources valid for 6 cycles (addrs 1/2/3) -> grant order 0,1,2,0,1,2; WE3 high 6 consecutive cycles with A3=1,2,3,1,2,3.
4. ISSUE_EN with rd=7, then CHK_A1=7 -> HAZARD=1. Src1 writes x7 -> HAZARD stays 1 through the WE3 cycle and drops to 0 the cycle after.
5. Same cycle: ISSUE_EN rd=9 while WE3=1, A3=9 -> busy[9] remains 1. Src2 write to x0 -> READY[2]=1, WE3 stays 0, busy[0]=0.
6. RST_N pulled low while WE3=1 and busy[4]=1 -> WE3=0 and SB_BUSY=0 immediately (async); after release, round-robin restarts at source 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DEF_NUM_SRC = 3;
  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_AW      = 5;

  // Architectural register count tracked by the scoreboard.
  localparam int unsigned NUM_REGS = 32;

  // x0 is hardwired to zero: writes to it are accepted but never committed.
  localparam logic [DEF_AW-1:0] REG_ZERO = 5'd0;

  // (base + off) mod n, assuming base < n and off < n.
  function automatic int unsigned wrap_add(int unsigned base, int unsigned off, int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus plus the registered register-file write port.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned AW      = DEF_AW
) ();

  logic [NUM_SRC-1:0]      req_valid;
  logic [NUM_SRC*AW-1:0]   req_addr;
  logic [NUM_SRC*XLEN-1:0] req_data;
  logic [NUM_SRC-1:0]      req_ready;
  logic                    we3;
  logic [AW-1:0]           a3;
  logic [XLEN-1:0]         wd3;

  // Requesters side: present writes, observe grants and the write port.
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, we3, a3, wd3
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, we3, a3, wd3
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the pointer, with wrap.
module regfile_wb_arbiter_rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic               gnt_valid
);

  localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;

  // Pick the first requester at or after the pointer.
  always_comb begin
    logic [PW-1:0] idx;
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = PW'(wrap_add(32'(ptr_q), k, NUM_SRC));
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // Advance past the winner so it becomes lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback units and tracks pending writes.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned AW      = DEF_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        chk_a1,
  input  logic [AW-1:0]        chk_a2,
  output logic                 hazard,
  output logic [NUM_REGS-1:0]  sb_busy
);

  logic [NUM_SRC-1:0]  req_masked;
  logic [NUM_SRC-1:0]  gnt;
  logic                gnt_valid;
  logic [AW-1:0]       sel_addr;
  logic [XLEN-1:0]     sel_data;

  logic                we3_q;
  logic [AW-1:0]       a3_q;
  logic [XLEN-1:0]     wd3_q;

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // No grants may leak out while reset is held.
  assign req_masked = bus.req_valid & {NUM_SRC{rst_n}};

  regfile_wb_arbiter_rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_masked),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  assign bus.req_ready = gnt;

  // One-hot mux of the granted source's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | bus.req_addr[i*AW +: AW];
        sel_data = sel_data | bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Registered write stage; x0 writes are consumed without a write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= gnt_valid && (sel_addr != AW'(REG_ZERO));
      if (gnt_valid) begin
        a3_q  <= sel_addr;
        wd3_q <= sel_data;
      end
    end
  end

  assign bus.we3 = we3_q;
  assign bus.a3  = a3_q;
  assign bus.wd3 = wd3_q;

  // Scoreboard next state: a new issue supersedes a same-cycle commit.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      if (issue_en && (issue_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (we3_q && (a3_q == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // Scoreboard register; bits stay set through the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read-after-write stall from registered busy bits only.
  always_comb begin
    hazard = ((chk_a1 != AW'(REG_ZERO)) && busy_q[chk_a1]) ||
             ((chk_a2 != AW'(REG_ZERO)) && busy_q[chk_a2]);
  end

  assign sb_busy = busy_q;

endmodule
